// File: rtl/i2c_bypass_arbiter.sv
// Two-master arbiter for a shared downstream I2C segment, with stuck-bus recovery.
// Optional master clock stretching while blocked: define I2C_BYPASS_ARB_STRETCH_EN.
`timescale 1ns/1ps
module i2c_bypass_arbiter #(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_CYC  = 65536,
  parameter int REC_HALF_CYC = 320,
  parameter int CNT_W        = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_m0_i,
  input  logic sda_m0_i,
  input  logic scl_m1_i,
  input  logic sda_m1_i,
  input  logic scl_s_i,
  input  logic sda_s_i,
  output logic grant_m0,
  output logic grant_m1,
  output logic blocked_m0,
  output logic blocked_m1,
  output logic rec_scl_oe,
  output logic rec_sda_oe,
  output logic rec_active,
  output logic rec_done,
  output logic stretch_m0,
  output logic stretch_m1
);

  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(REC_HALF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT0    = 3'd1,
    S_GRANT1    = 3'd2,
    S_REC_PULSE = 3'd3,
    S_REC_STOP  = 3'd4
  } state_e;

  function automatic logic start_cond(input logic scl_c, input logic scl_p,
                                      input logic sda_c, input logic sda_p);
    return scl_c & scl_p & sda_p & ~sda_c;
  endfunction

  function automatic logic stop_cond(input logic scl_c, input logic scl_p,
                                     input logic sda_c, input logic sda_p);
    return scl_c & scl_p & ~sda_p & sda_c;
  endfunction

  // Bit order of the sampled line vector: {sda_s, scl_s, sda_m1, scl_m1, sda_m0, scl_m0}
  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic [3:0]                  prev_q, prev_d;
  logic [5:0]                  cur_s;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             phase_q, phase_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [1:0]       sph_q, sph_d;
  logic             blk0_q, blk0_d, blk1_q, blk1_d;
  logic             done_q, done_d;
  logic             grant0_q, grant0_d, grant1_q, grant1_d;
  logic             scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic             active_q, active_d;
  logic             str0_q, str0_d, str1_q, str1_d;

  logic start0_s, start1_s, stop0_s, stop1_s, edge0_s, edge1_s, stuck_s, go_rec_s;

  assign cur_s    = sync_q[SYNC_STAGES-1];
  assign start0_s = start_cond(cur_s[0], prev_q[0], cur_s[1], prev_q[1]);
  assign start1_s = start_cond(cur_s[2], prev_q[2], cur_s[3], prev_q[3]);
  assign stop0_s  = stop_cond(cur_s[0], prev_q[0], cur_s[1], prev_q[1]);
  assign stop1_s  = stop_cond(cur_s[2], prev_q[2], cur_s[3], prev_q[3]);
  assign edge0_s  = cur_s[0] ^ prev_q[0];
  assign edge1_s  = cur_s[2] ^ prev_q[2];
  assign stuck_s  = cur_s[4] & ~cur_s[5];

  // Synchronizer chain and previous-sample stage for edge detection
  always_comb begin
    sync_d[0] = {sda_s_i, scl_s_i, sda_m1_i, scl_m1_i, sda_m0_i, scl_m0_i};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = cur_s[3:0];
  end

  // Synchronizer registers, preset high so reset looks like an idle bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 4'hF;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Arbitration / recovery next-state logic
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    tmo_d    = tmo_q;
    half_d   = half_q;
    phase_d  = phase_q;
    pcnt_d   = pcnt_q;
    sph_d    = sph_q;
    blk0_d   = blk0_q;
    blk1_d   = blk1_q;
    done_d   = 1'b0;
    go_rec_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start0_s && start1_s) begin
          state_d = rr_q ? S_GRANT1 : S_GRANT0;
          rr_d    = ~rr_q;
          tmo_d   = '0;
        end else if (start0_s) begin
          state_d = S_GRANT0;
          tmo_d   = '0;
        end else if (start1_s) begin
          state_d = S_GRANT1;
          tmo_d   = '0;
        end else if (stuck_s) begin
          if (tmo_q == TMO_LAST) go_rec_s = 1'b1;
          else                   tmo_d = tmo_q + CNT_ONE;
        end else begin
          tmo_d = '0;
        end
      end
      S_GRANT0: begin
        if (stop0_s) begin
          state_d = S_IDLE;
          tmo_d   = '0;
        end else if (edge0_s)         tmo_d = '0;
        else if (tmo_q == TMO_LAST)   go_rec_s = 1'b1;
        else                          tmo_d = tmo_q + CNT_ONE;
        blk1_d = blk1_q | start1_s;
      end
      S_GRANT1: begin
        if (stop1_s) begin
          state_d = S_IDLE;
          tmo_d   = '0;
        end else if (edge1_s)         tmo_d = '0;
        else if (tmo_q == TMO_LAST)   go_rec_s = 1'b1;
        else                          tmo_d = tmo_q + CNT_ONE;
        blk0_d = blk0_q | start0_s;
      end
      S_REC_PULSE: begin
        if (half_q != HALF_LAST) begin
          half_d = half_q + CNT_ONE;
        end else begin
          half_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of a high phase: one pulse completed, decide whether to stop
            pcnt_d = (pcnt_q == 4'd9) ? 4'd9 : pcnt_q + 4'd1;
            if (cur_s[5] || (pcnt_q >= 4'd8)) begin
              state_d = S_REC_STOP;
              sph_d   = 2'd0;
            end else begin
              phase_d = 1'b0;
            end
          end
        end
      end
      S_REC_STOP: begin
        if (half_q != HALF_LAST) begin
          half_d = half_q + CNT_ONE;
        end else begin
          half_d = '0;
          if (sph_q == 2'd2) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            tmo_d   = '0;
          end else begin
            sph_d = sph_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_rec_s) begin
      state_d = S_REC_PULSE;
      tmo_d   = '0;
      half_d  = '0;
      phase_d = 1'b0;
      pcnt_d  = 4'd0;
    end else begin
      state_d = state_d;
    end

    blk0_d = blk0_d & ~(stop0_s | (state_d == S_GRANT0));
    blk1_d = blk1_d & ~(stop1_s | (state_d == S_GRANT1));
  end

  // Output decode from next-state values so outputs are registered without extra lag
  always_comb begin
    grant0_d = (state_d == S_GRANT0);
    grant1_d = (state_d == S_GRANT1);
    active_d = (state_d == S_REC_PULSE) || (state_d == S_REC_STOP);
    scl_oe_d = ((state_d == S_REC_PULSE) && !phase_d) ||
               ((state_d == S_REC_STOP) && (sph_d == 2'd0));
    sda_oe_d = (state_d == S_REC_STOP) && (sph_d != 2'd2);
`ifdef I2C_BYPASS_ARB_STRETCH_EN
    str0_d = blk0_d & ~cur_s[0];
    str1_d = blk1_d & ~cur_s[2];
`else
    str0_d = 1'b0;
    str1_d = 1'b0;
`endif
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      tmo_q    <= '0;
      half_q   <= '0;
      phase_q  <= 1'b0;
      pcnt_q   <= 4'd0;
      sph_q    <= 2'd0;
      blk0_q   <= 1'b0;
      blk1_q   <= 1'b0;
      done_q   <= 1'b0;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      active_q <= 1'b0;
      str0_q   <= 1'b0;
      str1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      tmo_q    <= tmo_d;
      half_q   <= half_d;
      phase_q  <= phase_d;
      pcnt_q   <= pcnt_d;
      sph_q    <= sph_d;
      blk0_q   <= blk0_d;
      blk1_q   <= blk1_d;
      done_q   <= done_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      active_q <= active_d;
      str0_q   <= str0_d;
      str1_q   <= str1_d;
    end
  end

  assign grant_m0   = grant0_q;
  assign grant_m1   = grant1_q;
  assign blocked_m0 = blk0_q;
  assign blocked_m1 = blk1_q;
  assign rec_scl_oe = scl_oe_q;
  assign rec_sda_oe = sda_oe_q;
  assign rec_active = active_q;
  assign rec_done   = done_q;
  assign stretch_m0 = str0_q;
  assign stretch_m1 = str1_q;

endmodule

// File: tb/tb_i2c_bypass_arbiter.sv
// Directed bench for i2c_bypass_arbiter with a small downstream slave model.
`timescale 1ns/1ps
module tb_i2c_bypass_arbiter;
  localparam int SYNC_STAGES  = 2;
  localparam int TIMEOUT_CYC  = 64;
  localparam int REC_HALF_CYC = 8;
  localparam int CNT_W        = 17;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic scl_m0 = 1'b1, sda_m0 = 1'b1, scl_m1 = 1'b1, sda_m1 = 1'b1;
  logic scl_s, sda_s;
  logic grant_m0, grant_m1, blocked_m0, blocked_m1;
  logic rec_scl_oe, rec_sda_oe, rec_active, rec_done, stretch_m0, stretch_m1;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic hold_en = 1'b0;
  int   hold_limit = 0;
  int   pulses = 0, done_pulses = 0, done_cnt = 0;
  logic scl_oe_prev = 1'b0;
  logic slave_hold;
  logic exp_str;

  // Slave holds SDA low for hold_limit pulses (0 = forever), releasing as SCL rises
  assign slave_hold = hold_en && ((hold_limit == 0) || (pulses < hold_limit) ||
                                  ((pulses == hold_limit) && rec_scl_oe));
  assign scl_s = ~rec_scl_oe;
  assign sda_s = ~rec_sda_oe & ~slave_hold;

  always #5 clk = ~clk;

  i2c_bypass_arbiter #(
    .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC),
    .REC_HALF_CYC(REC_HALF_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .scl_m0_i(scl_m0), .sda_m0_i(sda_m0), .scl_m1_i(scl_m1), .sda_m1_i(sda_m1),
    .scl_s_i(scl_s), .sda_s_i(sda_s),
    .grant_m0(grant_m0), .grant_m1(grant_m1),
    .blocked_m0(blocked_m0), .blocked_m1(blocked_m1),
    .rec_scl_oe(rec_scl_oe), .rec_sda_oe(rec_sda_oe),
    .rec_active(rec_active), .rec_done(rec_done),
    .stretch_m0(stretch_m0), .stretch_m1(stretch_m1)
  );

  // Recovery pulse counter: a pulse starts when SCL is pulled low with SDA not driven
  always @(negedge clk) begin
    if (rec_done) begin
      done_pulses <= pulses;
      done_cnt    <= done_cnt + 1;
    end
    if (!rec_active) pulses <= 0;
    else if (rec_scl_oe && !scl_oe_prev && !rec_sda_oe) pulses <= pulses + 1;
    scl_oe_prev <= rec_scl_oe;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv(input int m, input logic c, input logic d);
    if (m == 0) begin scl_m0 = c; sda_m0 = d; end
    else        begin scl_m1 = c; sda_m1 = d; end
  endtask

  task automatic i2c_start(input int m);
    drv(m, 1'b1, 1'b0);
  endtask

  task automatic i2c_stop(input int m);
    drv(m, 1'b0, 1'b0); tick(1);
    drv(m, 1'b1, 1'b0); tick(1);
    drv(m, 1'b1, 1'b1);
  endtask

  task automatic send_byte(input int m, input logic [7:0] b);
    logic bit_v;
    drv(m, 1'b0, 1'b0); tick(1);
    for (int i = 0; i < 9; i++) begin
      bit_v = (i == 8) ? 1'b1 : b[7-i];
      drv(m, 1'b0, bit_v); tick(1);
      drv(m, 1'b1, bit_v); tick(1);
      drv(m, 1'b0, bit_v); tick(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(3);
  endtask

  task automatic test_reset();
    tick(3);
    n_cmp++;
    if ({grant_m0, grant_m1, blocked_m0, blocked_m1, rec_scl_oe, rec_sda_oe,
         rec_active, rec_done, stretch_m0, stretch_m1} !== 10'b0) begin
      n_bad++; $display("FAIL reset_during: outputs=%b want 0", {grant_m0, grant_m1,
        blocked_m0, blocked_m1, rec_scl_oe, rec_sda_oe, rec_active, rec_done, stretch_m0, stretch_m1});
    end
    reset = 1'b0; tick(3);
    n_cmp++;
    if ({grant_m0, grant_m1, blocked_m0, blocked_m1, rec_scl_oe, rec_sda_oe,
         rec_active, rec_done, stretch_m0, stretch_m1} !== 10'b0) begin
      n_bad++; $display("FAIL reset_after: outputs=%b want 0", {grant_m0, grant_m1,
        blocked_m0, blocked_m1, rec_scl_oe, rec_sda_oe, rec_active, rec_done, stretch_m0, stretch_m1});
    end
  endtask

  task automatic test_basic_grant();
    i2c_start(0); tick(2);
    n_cmp++; if (grant_m0 !== 1'b0) begin n_bad++; $display("FAIL grant_early: grant_m0=%b want 0", grant_m0); end
    tick(1);
    n_cmp++; if ({grant_m0, grant_m1} !== 2'b10) begin n_bad++; $display("FAIL grant_latency: grants=%b want 10", {grant_m0, grant_m1}); end
    send_byte(0, 8'hA0); send_byte(0, 8'h12); send_byte(0, 8'h5C);
    n_cmp++; if (grant_m0 !== 1'b1) begin n_bad++; $display("FAIL grant_hold: grant_m0=%b want 1", grant_m0); end
    i2c_stop(0); tick(2);
    n_cmp++; if (grant_m0 !== 1'b1) begin n_bad++; $display("FAIL stop_early: grant_m0=%b want 1", grant_m0); end
    tick(1);
    n_cmp++; if (grant_m0 !== 1'b0) begin n_bad++; $display("FAIL stop_drop: grant_m0=%b want 0", grant_m0); end
  endtask

  task automatic test_round_robin();
    do_reset();
    sda_m0 = 1'b0; sda_m1 = 1'b0; tick(3);
    n_cmp++; if ({grant_m0, grant_m1, blocked_m1} !== 3'b100) begin n_bad++; $display("FAIL rr_first: g0,g1,b1=%b want 100", {grant_m0, grant_m1, blocked_m1}); end
    i2c_stop(0); tick(4); i2c_stop(1); tick(4);
    n_cmp++; if ({grant_m0, grant_m1} !== 2'b00) begin n_bad++; $display("FAIL rr_idle: grants=%b want 00", {grant_m0, grant_m1}); end
    sda_m0 = 1'b0; sda_m1 = 1'b0; tick(3);
    n_cmp++; if ({grant_m0, grant_m1} !== 2'b01) begin n_bad++; $display("FAIL rr_second: grants=%b want 01", {grant_m0, grant_m1}); end
    i2c_stop(1); tick(4); i2c_stop(0); tick(4);
  endtask

  task automatic test_blocked();
    i2c_start(0); tick(3);
    i2c_start(1); tick(3);
    n_cmp++; if ({blocked_m1, grant_m1, grant_m0} !== 3'b101) begin n_bad++; $display("FAIL blk_set: b1,g1,g0=%b want 101", {blocked_m1, grant_m1, grant_m0}); end
    tick(2); drv(1, 1'b0, 1'b0); tick(3);
    n_cmp++; if (stretch_m1 !== exp_str) begin n_bad++; $display("FAIL blk_stretch: stretch_m1=%b want %b", stretch_m1, exp_str); end
    send_byte(0, 8'h3C);
    n_cmp++; if ({blocked_m1, grant_m1, stretch_m1} !== {1'b1, 1'b0, exp_str}) begin n_bad++; $display("FAIL blk_hold: b1,g1,s1=%b want 10%b", {blocked_m1, grant_m1, stretch_m1}, exp_str); end
    i2c_stop(0); tick(3);
    n_cmp++; if ({grant_m0, grant_m1, blocked_m1} !== 3'b001) begin n_bad++; $display("FAIL blk_after_stop: g0,g1,b1=%b want 001", {grant_m0, grant_m1, blocked_m1}); end
    drv(1, 1'b0, 1'b1); tick(1); drv(1, 1'b1, 1'b1); tick(3);
    n_cmp++; if (stretch_m1 !== 1'b0) begin n_bad++; $display("FAIL blk_scl_high: stretch_m1=%b want 0", stretch_m1); end
    i2c_start(1); tick(3);
    n_cmp++; if ({grant_m1, blocked_m1, stretch_m1} !== 3'b100) begin n_bad++; $display("FAIL blk_grant: g1,b1,s1=%b want 100", {grant_m1, blocked_m1, stretch_m1}); end
    i2c_stop(1); tick(3);
    n_cmp++; if (grant_m1 !== 1'b0) begin n_bad++; $display("FAIL blk_release: grant_m1=%b want 0", grant_m1); end
  endtask

  task automatic test_timeout_recovery();
    hold_limit = 4;
    i2c_start(0); tick(3);
    drv(0, 1'b0, 1'b0); hold_en = 1'b1; tick(40);
    n_cmp++; if ({rec_active, grant_m0} !== 2'b01) begin n_bad++; $display("FAIL tmo_early: rec_active,g0=%b want 01", {rec_active, grant_m0}); end
    for (int i = 0; i < 100 && rec_active !== 1'b1; i++) tick(1);
    n_cmp++; if ({rec_active, grant_m0, grant_m1} !== 3'b100) begin n_bad++; $display("FAIL tmo_enter: act,g0,g1=%b want 100", {rec_active, grant_m0, grant_m1}); end
    for (int i = 0; i < 300 && rec_sda_oe !== 1'b1; i++) tick(1);
    n_cmp++; if ({rec_sda_oe, rec_scl_oe} !== 2'b11) begin n_bad++; $display("FAIL stop_ph0: sda_oe,scl_oe=%b want 11", {rec_sda_oe, rec_scl_oe}); end
    tick(REC_HALF_CYC);
    n_cmp++; if ({rec_sda_oe, rec_scl_oe, rec_active} !== 3'b101) begin n_bad++; $display("FAIL stop_ph1: sda_oe,scl_oe,act=%b want 101", {rec_sda_oe, rec_scl_oe, rec_active}); end
    tick(REC_HALF_CYC);
    n_cmp++; if ({rec_sda_oe, rec_scl_oe, rec_active} !== 3'b001) begin n_bad++; $display("FAIL stop_ph2: sda_oe,scl_oe,act=%b want 001", {rec_sda_oe, rec_scl_oe, rec_active}); end
    tick(REC_HALF_CYC);
    n_cmp++; if ({rec_done, rec_active} !== 2'b10) begin n_bad++; $display("FAIL rec_done: done,act=%b want 10", {rec_done, rec_active}); end
    hold_en = 1'b0; tick(1);
    n_cmp++; if (rec_done !== 1'b0) begin n_bad++; $display("FAIL rec_done_pulse: rec_done=%b want 0", rec_done); end
    n_cmp++; if (done_pulses !== 4) begin n_bad++; $display("FAIL pulses_4: got %0d want 4", done_pulses); end
    drv(0, 1'b0, 1'b1); tick(1); drv(0, 1'b1, 1'b1); tick(3);
  endtask

  task automatic test_stuck_nine();
    int d0;
    hold_limit = 0; d0 = done_cnt; hold_en = 1'b1;
    for (int i = 0; i < 200 && rec_active !== 1'b1; i++) tick(1);
    n_cmp++; if (rec_active !== 1'b1) begin n_bad++; $display("FAIL stuck_enter: rec_active=%b want 1", rec_active); end
    tick(5); i2c_start(1);
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick(1);
    hold_en = 1'b0;
    n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL stuck_done: done count=%0d want %0d", done_cnt, d0 + 1); end
    n_cmp++; if (done_pulses !== 9) begin n_bad++; $display("FAIL pulses_9: got %0d want 9", done_pulses); end
    tick(5);
    n_cmp++; if ({rec_active, grant_m0, grant_m1} !== 3'b000) begin n_bad++; $display("FAIL pending_start: act,g0,g1=%b want 000", {rec_active, grant_m0, grant_m1}); end
    drv(1, 1'b0, 1'b0); tick(1); drv(1, 1'b0, 1'b1); tick(1); drv(1, 1'b1, 1'b1); tick(3);
  endtask

  task automatic test_reset_mid();
    i2c_start(1); tick(3);
    n_cmp++; if (grant_m1 !== 1'b1) begin n_bad++; $display("FAIL mid_grant1: grant_m1=%b want 1", grant_m1); end
    #2 reset = 1'b1; #1;
    n_cmp++; if ({grant_m0, grant_m1} !== 2'b00) begin n_bad++; $display("FAIL mid_reset_grant: grants=%b want 00", {grant_m0, grant_m1}); end
    drv(1, 1'b1, 1'b1); tick(2); reset = 1'b0; tick(2);
    i2c_start(0); tick(3);
    n_cmp++; if ({grant_m0, grant_m1} !== 2'b10) begin n_bad++; $display("FAIL mid_regrant0: grants=%b want 10", {grant_m0, grant_m1}); end
    i2c_stop(0); tick(3);
    hold_limit = 0; hold_en = 1'b1;
    for (int i = 0; i < 200 && rec_active !== 1'b1; i++) tick(1);
    tick(3);
    n_cmp++; if ({rec_active, rec_scl_oe} !== 2'b11) begin n_bad++; $display("FAIL mid_rec: act,scl_oe=%b want 11", {rec_active, rec_scl_oe}); end
    #2 reset = 1'b1; #1;
    n_cmp++; if ({rec_active, rec_scl_oe, rec_sda_oe, rec_done} !== 4'b0000) begin n_bad++; $display("FAIL mid_reset_rec: act,scl,sda,done=%b want 0000", {rec_active, rec_scl_oe, rec_sda_oe, rec_done}); end
    hold_en = 1'b0; tick(2); reset = 1'b0; tick(2);
    i2c_start(1); tick(3);
    n_cmp++; if ({grant_m0, grant_m1} !== 2'b01) begin n_bad++; $display("FAIL mid_regrant1: grants=%b want 01", {grant_m0, grant_m1}); end
    i2c_stop(1); tick(3);
  endtask

  initial begin
`ifdef I2C_BYPASS_ARB_STRETCH_EN
    exp_str = 1'b1;
`else
    exp_str = 1'b0;
`endif
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_blocked();
    test_timeout_recovery();
    test_stuck_nine();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
